// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the WISC pipeline stall controller.
`timescale 1ns/1ps
package pipe_ctrl_pkg;

  // Controller states: normal flow, I-side fill, D-side fill, terminal halt.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    I_FILL = 2'd1,
    D_FILL = 2'd2,
    HALTED = 2'd3
  } pipe_state_t;

  // Value driven on fill_sel to tell the memory which cache is being filled.
  localparam logic FILL_SEL_I = 1'b0;
  localparam logic FILL_SEL_D = 1'b1;

endpackage

// File: rtl/fill_timer.sv
// Loadable down-counter that times a cache line fill; zero flags the last cycle.
`timescale 1ns/1ps
module fill_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load on fill entry, otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register; reset abandons any fill in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline control for the 5-stage WISC core: turns hazards, branches,
// cache misses and HLT into write-enable / bubble controls for the PC and the
// IF/ID, ID/EX, EX/MEM, MEM/WB register banks.
// Optional build macro PIPE_STALL_PERF_EN adds a 16-bit stalled-cycle counter.
`timescale 1ns/1ps
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FILL_CYC = 4,
  parameter int CNT_W    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_use_hzd,
  input  logic        br_taken,
  input  logic        halt_id,
  input  logic        i_miss,
  input  logic        d_miss,
  output logic        pc_wen,
  output logic        ifid_wen,
  output logic        ifid_clr,
  output logic        idex_wen,
  output logic        idex_clr,
  output logic        exmem_wen,
  output logic        memwb_wen,
  output logic        memwb_clr,
  output logic        fill_req,
  output logic        fill_sel,
  output logic [15:0] stall_cyc
);

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_CYC - 1);

  pipe_state_t state_q;
  pipe_state_t state_d;
  logic        tmr_load;
  logic        tmr_zero;

  fill_timer #(
    .CNT_W(CNT_W)
  ) u_fill_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (FILL_LAST),
    .zero     (tmr_zero)
  );

  // Next state plus stage controls: Mealy on the event inputs in RUN,
  // purely state-driven in the fill and halt states.
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    pc_wen    = 1'b1;
    ifid_wen  = 1'b1;
    ifid_clr  = 1'b0;
    idex_wen  = 1'b1;
    idex_clr  = 1'b0;
    exmem_wen = 1'b1;
    memwb_wen = 1'b1;
    memwb_clr = 1'b0;
    fill_req  = 1'b0;
    fill_sel  = FILL_SEL_I;
    case (state_q)
      RUN: begin
        if (d_miss) begin
          // Freeze everything up to MEM; WB takes a bubble.
          pc_wen    = 1'b0;
          ifid_wen  = 1'b0;
          idex_wen  = 1'b0;
          exmem_wen = 1'b0;
          memwb_clr = 1'b1;
          state_d   = D_FILL;
          tmr_load  = 1'b1;
        end else if (i_miss) begin
          // Hold the PC, feed a bubble into ID, let older instructions drain.
          pc_wen   = 1'b0;
          ifid_clr = 1'b1;
          state_d  = I_FILL;
          tmr_load = 1'b1;
        end else if (ld_use_hzd) begin
          // Replay the consumer next cycle; a taken branch in ID is
          // re-evaluated then, so it is ignored here.
          pc_wen   = 1'b0;
          ifid_wen = 1'b0;
          idex_clr = 1'b1;
        end else if (br_taken) begin
          ifid_clr = 1'b1;
        end else if (halt_id) begin
          pc_wen   = 1'b0;
          ifid_clr = 1'b1;
          state_d  = HALTED;
        end
      end
      D_FILL: begin
        pc_wen    = 1'b0;
        ifid_wen  = 1'b0;
        idex_wen  = 1'b0;
        exmem_wen = 1'b0;
        memwb_clr = 1'b1;
        fill_req  = 1'b1;
        fill_sel  = FILL_SEL_D;
        if (tmr_zero) begin
          // A pending I-side miss is handed straight over to its own fill,
          // so no RUN cycle separates the two fills.
          if (i_miss) begin
            state_d  = I_FILL;
            tmr_load = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      I_FILL: begin
        pc_wen   = 1'b0;
        ifid_clr = 1'b1;
        fill_req = 1'b1;
        fill_sel = FILL_SEL_I;
        if (tmr_zero) begin
          state_d = RUN;
        end
      end
      HALTED: begin
        pc_wen   = 1'b0;
        ifid_wen = 1'b0;
        idex_clr = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State register; reset returns to RUN so fill_req drops with rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PIPE_STALL_PERF_EN
  logic [15:0] stall_cyc_q;
  logic [15:0] stall_cyc_d;

  // Count every cycle the PC is held; wraps naturally at 16 bits.
  always_comb begin
    stall_cyc_d = stall_cyc_q;
    if (!pc_wen) begin
      stall_cyc_d = stall_cyc_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc_q <= 16'h0000;
    end else begin
      stall_cyc_q <= stall_cyc_d;
    end
  end

  assign stall_cyc = stall_cyc_q;
`else
  assign stall_cyc = 16'h0000;
`endif

endmodule
